music_sequencer_player: RTL



---
 rtl/music_sequencer_player.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/music_sequencer_player.sv
`default_nettype none
// ============================================================================
// Module      : music_sequencer_player
// Description : Walks the note RAM from address 0, one note code per beat,
//               and drives a square-wave tone on the piezo beeper pin.
//               Playback starts and stops under a level play request.
//               After a song completes, play must go low before the song
//               can be replayed.
//
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   play     in   level play request (1 = play, 0 = stop)
//   addr     out  [7:0] note RAM read address
//   data     in   [4:0] note RAM read data, valid one clk after addr
//   beeper   out  square-wave piezo drive
//   busy     out  high while a song is being fetched or played
//   note_idx out  [7:0] index of the note currently sounding
//   done     out  one-cycle pulse at end of song
//
// Optional feature macro: MUSIC_LOOP_EN. When it is defined, the song
// restarts from index 0 after the done pulse for as long as play is held.
//
// Revision    : 1.0 - initial release
// ============================================================================
module music_sequencer_player #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned SONG_LEN    = 83,
    parameter int unsigned BEAT_CYCLES = 3000000,
    parameter int unsigned GAP_CYCLES  = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    output logic [7:0] addr,
    input  logic [4:0] data,
    output logic       beeper,
    output logic       busy,
    output logic [7:0] note_idx,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_TONE  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] c_tone_end = 32'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [31:0] c_beat_end = 32'(BEAT_CYCLES - 1);
    localparam logic [7:0]  c_last_idx = 8'(SONG_LEN - 1);
    localparam logic [4:0]  c_end_code = 5'd31;

    // Half-period in clocks for a note code; 0 marks a silent code.
    // Frequencies are held in millihertz so the rounding stays integer:
    // floor(CLK/(2f) + 0.5) == floor((CLK*1000 + f_mhz) / (2*f_mhz)).
    function automatic logic [15:0] half_period(input int unsigned code);
        logic [63:0] base_mhz;
        logic [63:0] f_mhz;
        base_mhz = 64'd0;
        f_mhz    = 64'd0;
        if (code >= 1 && code <= 21) begin
            case ((code - 1) % 7)
                0:       base_mhz = 64'd261630;
                1:       base_mhz = 64'd293660;
                2:       base_mhz = 64'd329630;
                3:       base_mhz = 64'd349230;
                4:       base_mhz = 64'd392000;
                5:       base_mhz = 64'd440000;
                default: base_mhz = 64'd493880;
            endcase
            f_mhz = base_mhz << ((code - 1) / 7);
            half_period = 16'((64'(CLK_HZ) * 64'd1000 + f_mhz) / (64'd2 * f_mhz));
        end else begin
            half_period = 16'd0;
        end
    endfunction

    logic [15:0] w_half_tab [32];

    for (genvar gi = 0; gi < 32; gi++) begin : g_half_tab
        assign w_half_tab[gi] = half_period(gi);
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_idx;
    logic [4:0]  r_note;
    logic [7:0]  r_note_idx;
    logic [31:0] r_beat;
    logic [15:0] r_tone;
    logic        r_beeper;
    logic        r_armed;
    logic [15:0] w_half;
    logic        w_abort;

    assign w_half  = w_half_tab[r_note];
    // Dropping play outside IDLE cancels the song immediately, even if the
    // song would otherwise end in the same cycle.
    assign w_abort = !play && (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (play && r_armed) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy         = 1'b1;
                w_state_next = S_LATCH;
            end
            S_LATCH: begin
                busy         = 1'b1;
                w_state_next = (data == c_end_code) ? S_DONE : S_TONE;
            end
            S_TONE: begin
                busy = 1'b1;
                if (r_beat == c_tone_end) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (r_beat == c_beat_end) begin
                    w_state_next = (r_idx == c_last_idx) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done = 1'b1;
`ifdef MUSIC_LOOP_EN
                w_state_next = S_FETCH;
`else
                w_state_next = S_IDLE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Note index, beat/tone counters and beeper
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= 8'd0;
            r_note     <= 5'd0;
            r_note_idx <= 8'd0;
            r_beat     <= 32'd0;
            r_tone     <= 16'd0;
            r_beeper   <= 1'b0;
        end else if (w_abort) begin
            r_idx      <= 8'd0;
            r_note_idx <= 8'd0;
            r_beat     <= 32'd0;
            r_tone     <= 16'd0;
            r_beeper   <= 1'b0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    r_note     <= data;
                    r_note_idx <= r_idx;
                    r_beat     <= 32'd0;
                    r_tone     <= 16'd0;
                    r_beeper   <= 1'b0;
                    // Index returns to 0 on the way into DONE so the
                    // address bus already reads 0 during the done pulse.
                    if (data == c_end_code) begin
                        r_idx <= 8'd0;
                    end
                end
                S_TONE: begin
                    r_beat <= r_beat + 32'd1;
                    if (r_beat == c_tone_end) begin
                        r_beeper <= 1'b0;
                        r_tone   <= 16'd0;
                    end else if (w_half != 16'd0) begin
                        if (r_tone == w_half - 16'd1) begin
                            r_tone   <= 16'd0;
                            r_beeper <= ~r_beeper;
                        end else begin
                            r_tone <= r_tone + 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_beat   <= r_beat + 32'd1;
                    r_beeper <= 1'b0;
                    if (r_beat == c_beat_end) begin
                        r_idx <= (r_idx == c_last_idx) ? 8'd0 : r_idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Replay arming: a finished song replays only after play has been low
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b1;
        end else if (r_state == S_IDLE && !play) begin
            r_armed <= 1'b1;
`ifndef MUSIC_LOOP_EN
        end else if (r_state == S_DONE) begin
            r_armed <= 1'b0;
`endif
        end
    end

    assign addr     = r_idx;
    assign beeper   = r_beeper;
    assign note_idx = r_note_idx;

endmodule
`default_nettype wire
